riot_6532: RTL
==============

// Module: riot_6532
// PURPOSE
//  RAM/I-O/Timer peripheral on the 6502 external bus, directly downstream of the CPU.
//  Decodes the 13-bit CPU address, serves 128 B work RAM, two 8-bit I/O ports
//  (console switches, joysticks) and the programmable interval timer with IRQ.
//  Bus writes commit on the clock edge. Read data is combinational during the bus cycle.
// PARAMETERS
//  PA7_EDGE_POS  0      PA7 edge-detect polarity: 0 = falling edge, 1 = rising edge
//  TIMER_RST     8'h00  INTIM value after reset
// PORTS
//  Clk       in   1  system clock; all state updates on rising edge
//  Reset     in   1  asynchronous, active-high reset
//  Bus_en    in   1  1 = one CPU bus cycle completes at this edge; all registers and the timer step only when Bus_en=1
//  R         in   1  CPU read strobe: 1 = read, 0 = write
//  Addr      in  13  CPU address A12..A0
//  Din       in   8  CPU write data
//  Dout      out  8  read data, valid while Dout_en=1
//  Dout_en   out  1  1 = this block drives the CPU data bus (selected & R=1)
//  PA_in     in   8  port A pin levels
//  PA_out    out  8  port A output register
//  PA_dir    out  8  port A direction; 1 = output
//  PB_in     in   8  port B pin levels
//  PB_out    out  8  port B output register
//  PB_dir    out  8  port B direction; 1 = output
//  Irq_n     out  1  active-low IRQ = ~(tim_flag & irq_en)
// BEHAVIOUR
//  Select: sel = ~A12 & A7. Not selected: Dout_en=0, no state change.
//  A9=0: RAM at A6..A0, with A8 ignored (0x080 mirrors 0x180).
//  A9=1,A2=0: I/O. A1:A0 = 0 SWCHA, 1 SWACNT, 2 SWCHB, 3 SWBCNT (R/W).
//  Port read value: (out & dir) | (in & ~dir). Direction-register reads return the register.
//  A9=1,A2=1,A4=1, write: timer load. Fields:
//   - A1:A0 = interval 1/8/64/1024.
//   - A3 = irq_en.
//  A9=1,A2=1,A4=0: writes are ignored.
//  A9=1,A2=1 read: A0=0 -> INTIM (count); A0=1 -> TIMINT = {tim_flag, pa7_flag, 6'b0}.
//  Reset: PA/PB out=0, dir=0, count=TIMER_RST, interval=1024, prescale=1023.
//   - Flags=0, irq_en=0, Irq_n=1, Dout_en=0.
//   - RAM is not cleared; its contents after reset are undefined and not checked.
//  Timer, evaluated per Bus_en edge, highest priority first:
//   1. Timer write: count<=Din, prescale<=interval-1, tim_flag<=0.
//   2. tim_flag=1: count<=count-1 every cycle (free-runs FF,FE,... and wraps).
//   3. prescale==0: prescale<=interval-1.
//      - count==0: count<=FF, tim_flag<=1.
//      - Otherwise: count<=count-1.
//   4. Otherwise: prescale<=prescale-1.
//  INTIM read clears tim_flag and sets prescale<=interval-1.
//   - A simultaneous underflow set wins over the clear.
//  pa7_flag: set on selected PA_in[7] edge (PA_in sampled each Bus_en edge).
//   - TIMINT read clears pa7_flag; a simultaneous edge wins over the clear.
//  Reads are side-effect free except INTIM and TIMINT as above.
//  Reset asserted mid-count aborts immediately to the reset values.
// TESTING
//  Reset -> Irq_n=1, PA_dir=PB_dir=00, read 0x284=TIMER_RST, read 0x285=00.
//  RAM: write 0x080=A5 and 0x0FF=3C -> read 0x080=A5, 0x0FF=3C, 0x180=A5 (mirror).
//  Write 0x294=03 (TIM1T) -> successive INTIM reads 02,01,00,FF with TIMINT bit7=1, then FE.
//   - TIMINT itself reads 80 while the flag is set.
//  Write 0x29E=01 (TIM64T, irq_en) -> INTIM=01 for 64 cycles, then 00 for 64, then FF.
//   - Irq_n goes 0 at the FF transition; an INTIM read returns Irq_n to 1.
//  Write SWACNT=F0, SWCHA=A5, drive PA_in=3C -> SWCHA read=AC, PA_out=A5, PA_dir=F0.
//  PA_in[7] 1->0 -> TIMINT=40 (0xC0 if tim_flag set); second TIMINT read=00.
//   - Also: Reset pulse mid T1024T count -> INTIM=TIMER_RST, interval back to 1024.

Source files
------------

// File: rtl/riot_6532.sv
// riot_6532: 6532-style RAM / I/O / interval-timer peripheral on the 6502 bus.
// Bus writes and timer steps commit on Clk when Bus_en=1; read data is combinational.
module riot_6532 #(
    parameter bit         PA7_EDGE_POS = 1'b0,
    parameter logic [7:0] TIMER_RST    = 8'h00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Bus_en,
    input  logic        R,
    input  logic [12:0] Addr,
    input  logic [7:0]  Din,
    output logic [7:0]  Dout,
    output logic        Dout_en,
    input  logic [7:0]  PA_in,
    output logic [7:0]  PA_out,
    output logic [7:0]  PA_dir,
    input  logic [7:0]  PB_in,
    output logic [7:0]  PB_out,
    output logic [7:0]  PB_dir,
    output logic        Irq_n
);

    // Prescaler reload value (interval - 1) for the four interval codes.
    function automatic logic [9:0] reload_of(input logic [1:0] sel);
        case (sel)
            2'd0:    reload_of = 10'd0;
            2'd1:    reload_of = 10'd7;
            2'd2:    reload_of = 10'd63;
            default: reload_of = 10'd1023;
        endcase
    endfunction

    logic [7:0] ram_r [0:127];
    logic [7:0] pa_out_r, pa_dir_r, pb_out_r, pb_dir_r;
    logic [7:0] count_r;
    logic [9:0] prescale_r;
    logic [1:0] interval_r;
    logic       tim_flag_r, irq_en_r, pa7_flag_r, pa7_prev_r, irq_n_r;

    logic       sel_s, ram_sel_s, io_sel_s, tim_sel_s, wr_s, rd_s;
    logic       ram_we_s, io_we_s, tim_we_s, intim_rd_s, timint_rd_s;
    logic       pa7_edge_s, underflow_s;
    logic [7:0] pa_val_s, pb_val_s, dout_s;
    logic [7:0] count_nx_s;
    logic [9:0] prescale_nx_s;
    logic [1:0] interval_nx_s;
    logic       tim_flag_nx_s, irq_en_nx_s;
    logic       addr_unused_s;

    // Address decode and access strobes; A8, A11 and A10 are don't-care.
    always_comb begin
        sel_s       = ~Addr[12] & Addr[7];
        ram_sel_s   = sel_s & ~Addr[9];
        io_sel_s    = sel_s & Addr[9] & ~Addr[2];
        tim_sel_s   = sel_s & Addr[9] & Addr[2];
        wr_s        = Bus_en & ~R & ~Reset;
        rd_s        = Bus_en & R & ~Reset;
        ram_we_s    = ram_sel_s & wr_s;
        io_we_s     = io_sel_s & wr_s;
        tim_we_s    = tim_sel_s & wr_s & Addr[4];
        intim_rd_s  = tim_sel_s & rd_s & ~Addr[0];
        timint_rd_s = tim_sel_s & rd_s & Addr[0];
        pa_val_s    = (pa_out_r & pa_dir_r) | (PA_in & ~pa_dir_r);
        pb_val_s    = (pb_out_r & pb_dir_r) | (PB_in & ~pb_dir_r);
        pa7_edge_s  = PA7_EDGE_POS ? (~pa7_prev_r & PA_in[7]) : (pa7_prev_r & ~PA_in[7]);
    end

    assign addr_unused_s = ^{Addr[11:10], Addr[8]};

    // Read data mux for the current bus cycle.
    always_comb begin
        dout_s = 8'h00;
        if (ram_sel_s) begin
            dout_s = ram_r[Addr[6:0]];
        end else if (io_sel_s) begin
            case (Addr[1:0])
                2'd0:    dout_s = pa_val_s;
                2'd1:    dout_s = pa_dir_r;
                2'd2:    dout_s = pb_val_s;
                default: dout_s = pb_dir_r;
            endcase
        end else if (tim_sel_s) begin
            dout_s = Addr[0] ? {tim_flag_r, pa7_flag_r, 6'b000000} : count_r;
        end else begin
            dout_s = 8'h00;
        end
    end

    // Timer next state: load, free-run after underflow, prescaled count-down.
    always_comb begin
        count_nx_s    = count_r;
        prescale_nx_s = prescale_r;
        interval_nx_s = interval_r;
        irq_en_nx_s   = irq_en_r;
        tim_flag_nx_s = tim_flag_r;
        underflow_s   = 1'b0;
        if (tim_we_s) begin
            count_nx_s    = Din;
            interval_nx_s = Addr[1:0];
            prescale_nx_s = reload_of(Addr[1:0]);
            irq_en_nx_s   = Addr[3];
            tim_flag_nx_s = 1'b0;
        end else begin
            if (tim_flag_r) begin
                count_nx_s    = count_r - 8'd1;
                prescale_nx_s = intim_rd_s ? reload_of(interval_r) : prescale_r;
            end else if (prescale_r == 10'd0) begin
                prescale_nx_s = reload_of(interval_r);
                if (count_r == 8'd0) begin
                    count_nx_s  = 8'hFF;
                    underflow_s = 1'b1;
                end else begin
                    count_nx_s = count_r - 8'd1;
                end
            end else begin
                prescale_nx_s = intim_rd_s ? reload_of(interval_r) : (prescale_r - 10'd1);
            end
            // an underflow in the same cycle as an INTIM read keeps the flag set
            if (underflow_s) begin
                tim_flag_nx_s = 1'b1;
            end else if (intim_rd_s) begin
                tim_flag_nx_s = 1'b0;
            end else begin
                tim_flag_nx_s = tim_flag_r;
            end
        end
    end

    // Ports, timer, PA7 edge flag and IRQ output; all advance only on bus cycles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pa_out_r   <= 8'h00;
            pa_dir_r   <= 8'h00;
            pb_out_r   <= 8'h00;
            pb_dir_r   <= 8'h00;
            count_r    <= TIMER_RST;
            prescale_r <= 10'd1023;
            interval_r <= 2'd3;
            tim_flag_r <= 1'b0;
            irq_en_r   <= 1'b0;
            pa7_flag_r <= 1'b0;
            pa7_prev_r <= PA7_EDGE_POS;
            irq_n_r    <= 1'b1;
        end else if (Bus_en) begin
            if (io_we_s) begin
                case (Addr[1:0])
                    2'd0:    pa_out_r <= Din;
                    2'd1:    pa_dir_r <= Din;
                    2'd2:    pb_out_r <= Din;
                    default: pb_dir_r <= Din;
                endcase
            end
            count_r    <= count_nx_s;
            prescale_r <= prescale_nx_s;
            interval_r <= interval_nx_s;
            tim_flag_r <= tim_flag_nx_s;
            irq_en_r   <= irq_en_nx_s;
            irq_n_r    <= ~(tim_flag_nx_s & irq_en_nx_s);
            pa7_prev_r <= PA_in[7];
            if (pa7_edge_s) begin
                pa7_flag_r <= 1'b1;
            end else if (timint_rd_s) begin
                pa7_flag_r <= 1'b0;
            end
        end
    end

    // Work RAM; contents are deliberately left uninitialised by reset.
    always_ff @(posedge Clk) begin
        if (ram_we_s) begin
            ram_r[Addr[6:0]] <= Din;
        end
    end

    assign Dout    = dout_s;
    assign Dout_en = sel_s & R & ~Reset;
    assign PA_out  = pa_out_r;
    assign PA_dir  = pa_dir_r;
    assign PB_out  = pb_out_r;
    assign PB_dir  = pb_dir_r;
    assign Irq_n   = irq_n_r;

endmodule
